// File: rtl/debounce_filter.sv
// debounce_filter: turns a raw, bouncing button level into a clean clk-synchronous level.
// Ports: clk (rising edge), rst_n (async active-low), btn_in (raw, async input),
//        btn_db (debounced level, registered), bouncing (a candidate change is being qualified),
//        long_press (btn_db held high for LONG_CYCLES edges).
// Optional feature: define DEBOUNCE_LONG_PRESS_EN to build the long-press hold counter;
//        without it long_press is tied to 0 and the port list does not change.
module debounce_filter #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES = 100000000,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_db,
  output logic bouncing,
  output logic long_press
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  state_t state, state_n;
  logic sync_q1, sync_q2, db_n, last;
  logic [CNT_W-1:0] cnt, cnt_n;
  if (STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_cfg
    $fatal(1, "debounce_filter: STABLE_CYCLES and LONG_CYCLES must be >= 1");
  end
  assign last = cnt == CNT_W'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state <= IDLE_LOW;
      cnt <= '0;
      btn_db <= 1'b0;
      bouncing <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
      state <= state_n;
      cnt <= cnt_n;
      btn_db <= db_n;
      bouncing <= state_n == WAIT_HIGH || state_n == WAIT_LOW;
    end
  // The counter defaults to 0 so any exit from a WAIT state restarts qualification.
  always_comb begin
    state_n = state;
    cnt_n = '0;
    db_n = btn_db;
    case (state)
      IDLE_LOW:  if (sync_q2) state_n = WAIT_HIGH;
      WAIT_HIGH:
        if (!sync_q2) state_n = IDLE_LOW;
        else if (last) begin
          state_n = IDLE_HIGH;
          db_n = 1'b1;
        end else cnt_n = cnt + CNT_W'(1);
      IDLE_HIGH: if (!sync_q2) state_n = WAIT_LOW;
      WAIT_LOW:
        if (sync_q2) state_n = IDLE_HIGH;
        else if (last) begin
          state_n = IDLE_LOW;
          db_n = 1'b0;
        end else cnt_n = cnt + CNT_W'(1);
    endcase
  end
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  logic [HOLD_W-1:0] hold;
  logic lp;
  // Clearing on db_n makes long_press and the hold count drop on the same edge as btn_db.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      lp <= 1'b0;
    end else if (!db_n) begin
      hold <= '0;
      lp <= 1'b0;
    end else begin
      if (btn_db && hold != HOLD_W'(LONG_CYCLES)) hold <= hold + HOLD_W'(1);
      if (btn_db && hold == HOLD_W'(LONG_CYCLES - 1)) lp <= 1'b1;
    end
  assign long_press = lp;
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: directed and random checks of debounce_filter against a run-length model.
module tb_debounce_filter;
  localparam int SC = 4;
  localparam int LC = 10;
  logic clk, rst_n, btn_in, btn_db, bouncing, long_press;
  int checks, failures;
  int m_q1, m_s, m_db, m_run, m_held, m_lp, m_rises, d_rises, prev_db;

  debounce_filter #(.STABLE_CYCLES(SC), .LONG_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_db(btn_db), .bouncing(bouncing), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q1 = 0; m_s = 0; m_db = 0; m_run = 0; m_held = 0; m_lp = 0;
  endtask

  // Model rule: btn_db flips once the synchronized input has disagreed with it for
  // SC+1 consecutive samples; any agreeing sample resets the run. Long press is
  // "btn_db has been high for at least LC edges".
  task automatic step(input logic b, input string tag);
    int was;
    btn_in = b;
    @(posedge clk);
    was = m_db;
    if (m_s != m_db) begin
      m_run++;
      if (m_run == SC + 1) begin
        m_db = m_s;
        m_run = 0;
      end
    end else m_run = 0;
    if (m_db == 1 && was == 0) begin
      m_held = 0;
      m_rises++;
    end else if (m_db == 1) m_held = (m_held < LC) ? m_held + 1 : LC;
    else m_held = 0;
`ifdef DEBOUNCE_LONG_PRESS_EN
    m_lp = (m_db == 1 && m_held >= LC) ? 1 : 0;
`else
    m_lp = 0;
`endif
    m_s = m_q1;
    m_q1 = int'(b);
    #1;
    if (btn_db && prev_db == 0) d_rises++;
    prev_db = int'(btn_db);
    chk({tag, "_db"}, int'(btn_db), m_db);
    chk({tag, "_bouncing"}, int'(bouncing), int'(m_run != 0));
    chk({tag, "_long"}, int'(long_press), m_lp);
  endtask

  initial begin
    int len;
    logic lvl;
    checks = 0; failures = 0; m_rises = 0; d_rises = 0; prev_db = 0;
    model_reset();
    btn_in = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset_db", int'(btn_db), 0);
    chk("reset_bouncing", int'(bouncing), 0);
    chk("reset_long", int'(long_press), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step(1'b0, "idle");
    // Press: first step's edge is edge k.
    for (int i = 0; i <= 6; i++) begin
      step(1'b1, "press");
      chk("lat_db", int'(btn_db), int'(i == 6));
      chk("lat_bouncing", int'(bouncing), int'(i >= 2 && i <= 5));
    end
    for (int i = 0; i < 24; i++) step(1'b1, "hold");
`ifdef DEBOUNCE_LONG_PRESS_EN
    chk("hold_long_set", int'(long_press), 1);
`else
    chk("hold_long_off", int'(long_press), 0);
`endif
    for (int i = 0; i <= 6; i++) begin
      step(1'b0, "release");
      chk("rel_db", int'(btn_db), int'(i != 6));
      chk("rel_long", int'(long_press), int'(long_press && i != 6));
    end
    for (int i = 0; i < 5; i++) step(1'b0, "gap");
    // Bounce: high 2, low 1, high 3, then low.
    for (int i = 0; i < 2; i++) step(1'b1, "bounce");
    step(1'b0, "bounce");
    for (int i = 0; i < 3; i++) step(1'b1, "bounce");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, "bounce");
      chk("bounce_db", int'(btn_db), 0);
    end
    chk("bounce_settled", int'(bouncing), 0);
    // Reset during the second cycle of WAIT_HIGH with btn_in held high.
    for (int i = 0; i < 4; i++) step(1'b1, "prereset");
    chk("prereset_bouncing", int'(bouncing), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_db", int'(btn_db), 0);
    chk("async_bouncing", int'(bouncing), 0);
    chk("async_long", int'(long_press), 0);
    #1 rst_n = 1'b1;
    prev_db = 0;
    for (int i = 0; i <= 6; i++) begin
      step(1'b1, "requal");
      chk("requal_db", int'(btn_db), int'(i == 6));
    end
    for (int i = 0; i < 8; i++) step(1'b0, "settle");
    // Random run lengths straddling the qualification window.
    lvl = 1'b0;
    for (int r = 0; r < 120; r++) begin
      lvl = ~lvl;
      len = (r % 4 == 0) ? int'($urandom_range(6, 16)) : int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) step(lvl, "rand");
    end
    for (int i = 0; i < 10; i++) step(1'b0, "tail");
    chk("rise_count", d_rises, m_rises);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
